// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue controller: opcode encodings, the
// 18-bit instruction word layout, the issue FSM state encoding and a helper
// that packs a request into an instruction word.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    localparam int INSTR_W = 18;
    localparam int OP_MSB  = 17;
    localparam int OP_LSB  = 16;
    localparam int A_MSB   = 15;
    localparam int A_LSB   = 8;
    localparam int B_MSB   = 7;
    localparam int B_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    function automatic logic [INSTR_W-1:0] pack_instr(input logic [1:0] op,
                                                      input logic [7:0] a,
                                                      input logic [7:0] b);
        logic [INSTR_W-1:0] w;
        w = '0;
        w[OP_MSB:OP_LSB] = op;
        w[A_MSB:A_LSB]   = a;
        w[B_MSB:B_LSB]   = b;
        return w;
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// -----------------------------------------------------------------------------
// alu_req_fifo
// Synchronous show-ahead FIFO holding packed ALU instruction words.
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties the FIFO)
//   push, wr_data   write request and data (ignored when full)
//   pop             read request (ignored when empty)
//   rd_data         head entry, valid whenever empty is low
//   full, empty     occupancy flags
// -----------------------------------------------------------------------------
module alu_req_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = INSTR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: storage is not reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
// Initiator side of the 8-bit ALU instruction interface. Requests are queued
// in alu_req_fifo, issued one at a time on instr_out, held for SETTLE_CYCLES,
// and the ALU outputs are captured into a response register.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            request handshake (req_ready = !fifo full)
//   req_op, req_a, req_b           opcode and signed operands
//   instr_out                      {op, A, B} driven to the ALU
//   alu_x, alu_y, alu_carry, alu_ovf  combinational ALU results
//   rsp_valid/rsp_ready            response handshake
//   rsp_op, rsp_x, rsp_y           captured opcode and results
//   rsp_carry, rsp_ovf             captured flags, zero unless op is ADD
//   busy                           FSM active or requests queued
// Optional build macro ALU_ISSUE_STATS_EN adds saturating counters:
//   stat_issued                    response handshakes
//   stat_ovf                       response handshakes with rsp_ovf set
// -----------------------------------------------------------------------------
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic [7:0]         req_a,
    input  logic [7:0]         req_b,
    output logic [INSTR_W-1:0] instr_out,
    input  logic [7:0]         alu_x,
    input  logic [7:0]         alu_y,
    input  logic               alu_carry,
    input  logic               alu_ovf,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [1:0]         rsp_op,
    output logic [7:0]         rsp_x,
    output logic [7:0]         rsp_y,
    output logic               rsp_carry,
    output logic               rsp_ovf,
`ifdef ALU_ISSUE_STATS_EN
    output logic [15:0]        stat_issued,
    output logic [15:0]        stat_ovf,
`endif
    output logic               busy
);

    localparam int              CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_e             state_q;
    logic [INSTR_W-1:0] instr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               rsp_valid_q;
    logic [1:0]         rsp_op_q;
    logic [7:0]         rsp_x_q;
    logic [7:0]         rsp_y_q;
    logic               rsp_carry_q;
    logic               rsp_ovf_q;

    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic [INSTR_W-1:0] fifo_rd_data;
    logic               is_add;

    alu_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (req_valid),
        .wr_data (pack_instr(req_op, req_a, req_b)),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Pop when idle, or when the held response is consumed so the next
    // request issues without a detour through IDLE.
    assign fifo_pop = !fifo_empty &&
                      ((state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready));
    assign is_add   = (instr_q[OP_MSB:OP_LSB] == OP_ADD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            instr_q     <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_op_q    <= '0;
            rsp_x_q     <= '0;
            rsp_y_q     <= '0;
            rsp_carry_q <= 1'b0;
            rsp_ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        instr_q <= fifo_rd_data;
                        cnt_q   <= CNT_LOAD;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (cnt_q == '0) begin
                        rsp_op_q    <= instr_q[OP_MSB:OP_LSB];
                        rsp_x_q     <= alu_x;
                        rsp_y_q     <= alu_y;
                        rsp_carry_q <= is_add && alu_carry;
                        rsp_ovf_q   <= is_add && alu_ovf;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (fifo_pop) begin
                            instr_q <= fifo_rd_data;
                            cnt_q   <= CNT_LOAD;
                            state_q <= ST_ISSUE;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] stat_issued_q;
    logic [15:0] stat_ovf_q;
    logic        rsp_fire;

    assign rsp_fire = rsp_valid_q && rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued_q <= '0;
            stat_ovf_q    <= '0;
        end else if (rsp_fire) begin
            if (stat_issued_q != 16'hFFFF) stat_issued_q <= stat_issued_q + 16'd1;
            if (rsp_ovf_q && (stat_ovf_q != 16'hFFFF)) stat_ovf_q <= stat_ovf_q + 16'd1;
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_ovf    = stat_ovf_q;
`endif

    assign req_ready = !fifo_full;
    assign instr_out = instr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_op    = rsp_op_q;
    assign rsp_x     = rsp_x_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign busy      = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Self-checking bench for alu_issue_ctrl with a behavioural ALU attached to
// instr_out. Accepted requests push their expected response into a queue;
// every response handshake pops and compares. Build with ALU_ISSUE_STATS_EN
// defined to also exercise the statistics counters.
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] x;
        logic [7:0] y;
        logic       c;
        logic       o;
    } rsp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    logic [1:0]         req_op;
    logic [7:0]         req_a;
    logic [7:0]         req_b;
    logic [INSTR_W-1:0] instr_out;
    logic [7:0]         alu_x;
    logic [7:0]         alu_y;
    logic               alu_carry;
    logic               alu_ovf;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [1:0]         rsp_op;
    logic [7:0]         rsp_x;
    logic [7:0]         rsp_y;
    logic               rsp_carry;
    logic               rsp_ovf;
    logic               busy;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0]        stat_issued;
    logic [15:0]        stat_ovf;
`endif

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   fire_cnt = 0;
    int   last_fire_cyc = 0;
    int   prev_fire_cyc = 0;
    int   valid_seen = 0;
    rsp_t sb_q[$];
    rsp_t alu_m;

    always #5 clk = ~clk;

    alu_issue_ctrl #(
        .FIFO_DEPTH    (4),
        .SETTLE_CYCLES (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .instr_out   (instr_out),
        .alu_x       (alu_x),
        .alu_y       (alu_y),
        .alu_carry   (alu_carry),
        .alu_ovf     (alu_ovf),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_op      (rsp_op),
        .rsp_x       (rsp_x),
        .rsp_y       (rsp_y),
        .rsp_carry   (rsp_carry),
        .rsp_ovf     (rsp_ovf),
`ifdef ALU_ISSUE_STATS_EN
        .stat_issued (stat_issued),
        .stat_ovf    (stat_ovf),
`endif
        .busy        (busy)
    );

    // Reference ALU result with carry/overflow already masked for non-ADD ops.
    function automatic rsp_t model(input logic [1:0] op, input logic [7:0] a,
                                   input logic [7:0] b);
        rsp_t               r;
        logic [8:0]         s;
        logic signed [15:0] p;
        r    = '0;
        r.op = op;
        case (op)
            OP_ADD: begin
                s   = {1'b0, a} + {1'b0, b};
                r.y = s[7:0];
                r.c = s[8];
                r.o = (a[7] == b[7]) && (s[7] != a[7]);
            end
            OP_MUL: begin
                p   = $signed(a) * $signed(b);
                r.x = p[15:8];
                r.y = p[7:0];
            end
            OP_AND:  r.y = a & b;
            default: r.y = a ^ b;
        endcase
        return r;
    endfunction

    // Behavioural ALU: drives carry/overflow high for non-ADD ops so the
    // DUT's masking is exercised.
    assign alu_m     = model(instr_out[OP_MSB:OP_LSB], instr_out[A_MSB:A_LSB],
                             instr_out[B_MSB:B_LSB]);
    assign alu_x     = alu_m.x;
    assign alu_y     = alu_m.y;
    assign alu_carry = (alu_m.op == OP_ADD) ? alu_m.c : 1'b1;
    assign alu_ovf   = (alu_m.op == OP_ADD) ? alu_m.o : 1'b1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: sampled on the falling edge, so the handshakes seen here
    // are the ones the next rising edge performs.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (rsp_valid) valid_seen++;
            if (rsp_valid && rsp_ready) begin
                fire_cnt++;
                prev_fire_cyc = last_fire_cyc;
                last_fire_cyc = cyc;
                if (sb_q.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    check("rsp", {rsp_op, rsp_x, rsp_y, rsp_carry, rsp_ovf},
                          sb_q.pop_front());
                end
            end
            if (req_valid && req_ready) sb_q.push_back(model(req_op, req_a, req_b));
        end
    end

    task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        bit ok = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !busy && !rsp_valid) begin
                ok = 1;
                break;
            end
        end
        check("drain", 32'(ok), 32'd1);
    endtask

    // Single request with rsp_ready high and an empty FIFO: instr_out one edge
    // after acceptance, rsp_valid two edges after.
    task automatic latency_case(input string tag, input logic [1:0] op,
                                input logic [7:0] a, input logic [7:0] b,
                                input logic [17:0] exp_instr, input rsp_t exp_rsp);
        send(op, a, b);
        @(negedge clk);
        check({tag, "_valid_e0"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check({tag, "_instr"}, 32'(instr_out), 32'(exp_instr));
        check({tag, "_valid_e1"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check({tag, "_valid_e2"}, 32'(rsp_valid), 32'd1);
        check({tag, "_data"}, 32'({rsp_op, rsp_x, rsp_y, rsp_carry, rsp_ovf}), 32'(exp_rsp));
        wait_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   acc;
        int   fc0;
        bit   rnd_done;
        rsp_t held_exp;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_instr", 32'(instr_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_fields", 32'({rsp_op, rsp_x, rsp_y, rsp_carry, rsp_ovf}), 32'd0);
        @(posedge clk);
        #1;

        // ADD overflow and MUL with masked flags
        latency_case("add", OP_ADD, 8'h7F, 8'h01, 18'h07F01,
                     '{op: OP_ADD, x: 8'h00, y: 8'h80, c: 1'b0, o: 1'b1});
        @(posedge clk);
        #1;
        latency_case("mul", OP_MUL, 8'h10, 8'h10, 18'h11010,
                     '{op: OP_MUL, x: 8'h01, y: 8'h00, c: 1'b0, o: 1'b0});
        @(posedge clk);
        #1;

        // Back-to-back AND then XOR: one result every two cycles
        fc0 = fire_cnt;
        send(OP_AND, 8'hF0, 8'h3C);
        send(OP_XOR, 8'hF0, 8'h3C);
        wait_idle();
        check("b2b_count", 32'(fire_cnt - fc0), 32'd2);
        check("b2b_spacing", 32'(last_fire_cyc - prev_fire_cyc), 32'd2);
        @(posedge clk);
        #1;

        // Backpressure: 7 offered, 4 queued + 1 in flight accepted
        rsp_ready = 1'b0;
        acc = 0;
        fc0 = fire_cnt;
        for (int i = 0; i < 7; i++) begin
            req_valid = 1'b1;
            req_op    = 2'(i);
            req_a     = 8'(8'h21 * (i + 1));
            req_b     = 8'(8'h5B + 3 * i);
            if (i == 0) held_exp = model(2'(i), req_a, req_b);
            @(negedge clk);
            if (req_ready) acc++;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        check("bp_accepted", 32'(acc), 32'd5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_held_valid", 32'(rsp_valid), 32'd1);
            check("bp_held_rsp", 32'({rsp_op, rsp_x, rsp_y, rsp_carry, rsp_ovf}), 32'(held_exp));
            check("bp_held_instr", 32'(instr_out),
                  32'(pack_instr(2'd0, 8'h21, 8'h5B)));
        end
        rsp_ready = 1'b1;
        wait_idle();
        check("bp_responses", 32'(fire_cnt - fc0), 32'd5);
        check("bp_req_ready_after", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;

        // Random stream under random backpressure
        rnd_done = 0;
        fork
            begin
                for (int i = 0; i < 20; i++)
                    send(2'($urandom_range(3)), 8'($urandom), 8'($urandom));
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(negedge clk);
                    rsp_ready = 1'($urandom_range(1));
                end
            end
        join
        rsp_ready = 1'b1;
        wait_idle();
        @(posedge clk);
        #1;

        // Reset while ISSUE with three requests queued
        rsp_ready = 1'b0;
        send(OP_ADD, 8'h01, 8'h02);
        send(OP_MUL, 8'h03, 8'h04);
        send(OP_AND, 8'h05, 8'h06);
        send(OP_XOR, 8'h07, 8'h08);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_op    = OP_ADD;
        req_a     = 8'h09;
        req_b     = 8'h0A;
        @(negedge clk);
        check("rstmid_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        check("rstmid_busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        check("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstmid_instr", 32'(instr_out), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        valid_seen = 0;
        repeat (10) @(negedge clk);
        check("rstmid_no_stale", 32'(valid_seen), 32'd0);
        @(posedge clk);
        #1;

`ifdef ALU_ISSUE_STATS_EN
        check("stats_reset", 32'({stat_issued, stat_ovf}), 32'd0);
        send(OP_ADD, 8'h01, 8'h02);
        send(OP_ADD, 8'h7F, 8'h7F);
        send(OP_ADD, 8'h03, 8'h04);
        wait_idle();
        check("stat_issued", 32'(stat_issued), 32'd3);
        check("stat_ovf", 32'(stat_ovf), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
